// File: rtl/aes128_sbox_arbiter.sv
// Round-robin arbiter sharing one combinational AES S-box between NUM_REQ requesters,
// with bounded burst locking and a registered one-cycle-later result return.
module aes128_sbox_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int MAX_LOCK = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   lock_i,
    input  logic [NUM_REQ*8-1:0] byte_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [NUM_REQ-1:0]   rsp_valid_o,
    output logic [7:0]           rsp_data_o,
    output logic [7:0]           sbox_addr_o,
    input  logic [7:0]           sbox_data_i,
    output logic                 busy_o
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [PTR_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
    logic [PTR_W-1:0]   lock_owner_r, lock_owner_nxt_s;
    logic [7:0]         lock_cnt_r, lock_cnt_nxt_s;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [7:0]         rsp_data_r;
    logic               busy_r;

    logic [NUM_REQ-1:0] owner_oh_s;
    logic [NUM_REQ-1:0] arb_mask_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic               arb_found_s;
    logic [PTR_W-1:0]   arb_idx_s;
    logic               owner_req_s;
    logic               others_s;
    logic               sat_s;
    logic [7:0]         sbox_addr_s;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (int'(p) == NUM_REQ - 1) begin
            ptr_next = {PTR_W{1'b0}};
        end else begin
            ptr_next = p + 1'b1;
        end
    endfunction

    // One-hot decode of the current lock owner
    always_comb begin
        owner_oh_s = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            owner_oh_s[k] = (PTR_W'(k) == lock_owner_r);
        end
    end

    assign owner_req_s = req_i[lock_owner_r];
    assign others_s    = |(req_i & ~owner_oh_s);
    assign sat_s       = (lock_cnt_r == 8'(MAX_LOCK));
    // In LOCK the arbiter only runs when the owner is idle or is being preempted,
    // so excluding the owner is harmless in the idle case.
    assign arb_mask_s  = (state_r == ST_LOCK) ? (req_i & ~owner_oh_s) : req_i;

    // Round-robin search: first requester at or above rr_ptr, then wrap to the bottom
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!arb_found_s && arb_mask_s[k] && (PTR_W'(k) >= rr_ptr_r)) begin
                arb_found_s = 1'b1;
                arb_idx_s   = PTR_W'(k);
            end else begin
                arb_found_s = arb_found_s;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!arb_found_s && arb_mask_s[k]) begin
                arb_found_s = 1'b1;
                arb_idx_s   = PTR_W'(k);
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Grant selection and next-state logic
    always_comb begin
        state_nxt_s      = state_r;
        rr_ptr_nxt_s     = rr_ptr_r;
        lock_owner_nxt_s = lock_owner_r;
        lock_cnt_nxt_s   = lock_cnt_r;
        gnt_s            = {NUM_REQ{1'b0}};
        if ((state_r == ST_LOCK) && owner_req_s && !(sat_s && others_s)) begin
            gnt_s = owner_oh_s;
            if (sat_s) begin
                lock_cnt_nxt_s = lock_cnt_r;
            end else begin
                lock_cnt_nxt_s = lock_cnt_r + 8'd1;
            end
            if (lock_i[lock_owner_r]) begin
                state_nxt_s = ST_LOCK;
            end else begin
                state_nxt_s = ST_ARB;
            end
        end else begin
            state_nxt_s = ST_ARB;
            if (arb_found_s) begin
                gnt_s[arb_idx_s] = 1'b1;
                rr_ptr_nxt_s     = ptr_next(arb_idx_s);
                if (lock_i[arb_idx_s]) begin
                    state_nxt_s      = ST_LOCK;
                    lock_owner_nxt_s = arb_idx_s;
                    lock_cnt_nxt_s   = 8'd1;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end else begin
                rr_ptr_nxt_s = rr_ptr_r;
            end
        end
    end

    assign gnt_o = rst_i ? {NUM_REQ{1'b0}} : gnt_s;

    // Grants are one-hot, so an OR of the gated bytes is the address mux
    always_comb begin
        sbox_addr_s = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_o[k]) begin
                sbox_addr_s = sbox_addr_s | byte_i[k*8 +: 8];
            end else begin
                sbox_addr_s = sbox_addr_s;
            end
        end
    end

    assign sbox_addr_o = sbox_addr_s;

    // Arbiter state and registered response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_ARB;
            rr_ptr_r     <= {PTR_W{1'b0}};
            lock_owner_r <= {PTR_W{1'b0}};
            lock_cnt_r   <= 8'd0;
            rsp_valid_r  <= {NUM_REQ{1'b0}};
            rsp_data_r   <= 8'h00;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            rr_ptr_r     <= rr_ptr_nxt_s;
            lock_owner_r <= lock_owner_nxt_s;
            lock_cnt_r   <= lock_cnt_nxt_s;
            rsp_valid_r  <= gnt_s;
            if (|gnt_s) begin
                rsp_data_r <= sbox_data_i;
            end
            busy_r       <= (state_nxt_s == ST_LOCK);
        end
    end

    assign rsp_valid_o = rsp_valid_r;
    assign rsp_data_o  = rsp_data_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_aes128_sbox_arbiter.sv
// Bench for aes128_sbox_arbiter: spec vector table, directed lock/reset sequences,
// and random traffic compared against a rule-level arbitration model.
module tb_aes128_sbox_arbiter;
    localparam int N     = 2;
    localparam int ML    = 16;
    localparam int BOUND = ML + N - 1;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic           clk_i;
    logic           rst_i;
    logic [N-1:0]   req_i;
    logic [N-1:0]   lock_i;
    logic [N*8-1:0] byte_i;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   rsp_valid_o;
    logic [7:0]     rsp_data_o;
    logic [7:0]     sbox_addr_o;
    logic [7:0]     sbox_data_i;
    logic           busy_o;

    aes128_sbox_arbiter #(.NUM_REQ(N), .MAX_LOCK(ML)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .lock_i(lock_i), .byte_i(byte_i),
        .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .sbox_addr_o(sbox_addr_o), .sbox_data_i(sbox_data_i), .busy_o(busy_o)
    );

    assign sbox_data_i = SBOX[sbox_addr_o];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: arbitration rules stated directly
    int           m_rr;
    bit           m_locked;
    int           m_owner;
    int           m_cnt;
    logic [N-1:0] m_prev_gnt;
    logic [7:0]   m_rsp_data;
    int           wt [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int start, input int excl);
        int r = -1;
        for (int i = 0; i < N; i++) begin
            int c = (start + i) % N;
            if (r < 0 && req[c] && c != excl) r = c;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_locked = 1'b0; m_owner = 0; m_cnt = 0;
        m_prev_gnt = '0; m_rsp_data = 8'h00;
        for (int k = 0; k < N; k++) wt[k] = 0;
    endtask

    // Called at posedge+1; drives one cycle, checks at negedge, returns at next posedge+1
    task automatic run_cycle(input logic [N-1:0] req, input logic [N-1:0] lock, input logic [N*8-1:0] bytes,
                             output logic [N-1:0] g, output logic [N-1:0] v, output logic [7:0] d, output logic b);
        int win;
        int excl;
        bit others;
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_valid;
        logic [7:0]   e_addr;
        logic [7:0]   e_data;
        logic         e_busy;
        req_i = req; lock_i = lock; byte_i = bytes;
        e_valid = m_prev_gnt; e_data = m_rsp_data; e_busy = m_locked;
        others = 1'b0;
        for (int k = 0; k < N; k++) if (k != m_owner && req[k]) others = 1'b1;
        if (m_locked && req[m_owner] && !(m_cnt == ML && others)) begin
            win = m_owner;
            if (m_cnt < ML) m_cnt++;
            m_locked = lock[m_owner];
        end else begin
            excl = (m_locked && req[m_owner]) ? m_owner : -1;
            win = rr_pick(req, m_rr, excl);
            m_locked = 1'b0;
            if (win >= 0) begin
                m_rr = (win + 1) % N;
                if (lock[win]) begin m_locked = 1'b1; m_owner = win; m_cnt = 1; end
            end
        end
        e_gnt = '0; e_addr = 8'h00;
        if (win >= 0) begin e_gnt = 2'b01 << win; e_addr = bytes[win*8 +: 8]; end
        @(negedge clk_i);
        g = gnt_o; v = rsp_valid_o; d = rsp_data_o; b = busy_o;
        chk("gnt", 32'(g), 32'(e_gnt));
        chk("sbox_addr", 32'(sbox_addr_o), 32'(e_addr));
        chk("rsp_valid", 32'(v), 32'(e_valid));
        chk("rsp_data", 32'(d), 32'(e_data));
        chk("busy", 32'(b), 32'(e_busy));
        chk("onehot", 32'($onehot0(g)), 32'd1);
        for (int k = 0; k < N; k++) begin
            if (req[k] && g[k]) begin
                n_cmp++;
                if (wt[k] > BOUND) begin
                    n_fail++;
                    $display("FAIL starve req%0d: waited %0d cycles, limit %0d", k, wt[k], BOUND);
                end
                wt[k] = 0;
            end else if (req[k]) begin
                wt[k]++;
            end else begin
                wt[k] = 0;
            end
        end
        m_prev_gnt = e_gnt;
        if (win >= 0) m_rsp_data = SBOX[e_addr];
        @(posedge clk_i); #1;
    endtask

    // Holds reset across an edge with a pending request; gnt must stay low
    task automatic do_reset();
        rst_i = 1'b1; req_i = 2'b01; lock_i = 2'b00; byte_i = '0;
        @(negedge clk_i);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_addr", 32'(sbox_addr_o), 32'd0);
        chk("rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_data", 32'(rsp_data_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; req_i = 2'b00;
        model_reset();
    endtask

    typedef struct {
        bit         rst_before;
        logic [1:0] req;
        logic [1:0] lock;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [1:0] gnt;
        logic [1:0] valid;
        logic [7:0] data;
        logic       busy;
    } vec_t;

    initial begin
        vec_t       vecs [7];
        logic [7:0] t3_exp [4];
        logic [N-1:0] g;
        logic [N-1:0] v;
        logic [7:0]   d;
        logic         b;
        logic [N-1:0] rq;
        logic [N-1:0] lk;
        logic [N-1:0] pend;
        logic [7:0]   rb [N];
        int           w1;
        int           pct [3];

        vecs[0] = '{1'b1, 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b01, 8'h63, 1'b0};
        vecs[2] = '{1'b1, 2'b11, 2'b00, 8'h53, 8'h01, 2'b01, 2'b00, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 2'b11, 2'b00, 8'h53, 8'h01, 2'b10, 2'b01, 8'hed, 1'b0};
        vecs[4] = '{1'b0, 2'b11, 2'b00, 8'h53, 8'h01, 2'b01, 2'b10, 8'h7c, 1'b0};
        vecs[5] = '{1'b0, 2'b11, 2'b00, 8'h53, 8'h01, 2'b10, 2'b01, 8'hed, 1'b0};
        vecs[6] = '{1'b0, 2'b00, 2'b00, 8'h53, 8'h01, 2'b00, 2'b10, 8'h7c, 1'b0};
        t3_exp  = '{8'h63, 8'h7c, 8'h77, 8'h7b};
        pct     = '{0, 50, 95};

        rst_i = 1'b1; req_i = '0; lock_i = '0; byte_i = '0;
        model_reset();

        // Single lookup and round-robin alternation
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].rst_before) do_reset();
            run_cycle(vecs[i].req, vecs[i].lock, {vecs[i].b1, vecs[i].b0}, g, v, d, b);
            chk("tbl_gnt", 32'(g), 32'(vecs[i].gnt));
            chk("tbl_valid", 32'(v), 32'(vecs[i].valid));
            chk("tbl_data", 32'(d), 32'(vecs[i].data));
            chk("tbl_busy", 32'(b), 32'(vecs[i].busy));
        end

        // Burst of 16 locked lookups, lock released on the last one
        do_reset();
        for (int i = 0; i < 16; i++) begin
            lk = (i < 15) ? 2'b01 : 2'b00;
            run_cycle(2'b01, lk, {8'h00, 8'(i)}, g, v, d, b);
            chk("t3_gnt", 32'(g), 32'd1);
            chk("t3_busy", 32'(b), (i >= 1) ? 32'd1 : 32'd0);
            if (i < 4) chk("t3_result", 32'(rsp_data_o), 32'(t3_exp[i]));
        end
        run_cycle(2'b00, 2'b00, '0, g, v, d, b);
        chk("t3_busy_off", 32'(b), 32'd0);

        // Lock preempted at MAX_LOCK by a waiting requester
        do_reset();
        w1 = 0;
        for (int i = 1; i <= 18; i++) begin
            rq = (i >= 3 && i <= 17) ? 2'b11 : 2'b01;
            run_cycle(rq, 2'b01, {8'h53, 8'(i)}, g, v, d, b);
            if (rq[1] && !g[1]) w1++;
            if (i <= 16) chk("t4_gnt_owner", 32'(g), 32'd1);
            else if (i == 17) chk("t4_gnt_preempt", 32'(g), 32'd2);
            else chk("t4_gnt_resume", 32'(g), 32'd1);
        end
        chk("t4_wait", 32'(w1), 32'd14);

        // Asynchronous reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 3; i++) run_cycle(2'b01, 2'b01, {8'h00, 8'h10}, g, v, d, b);
        chk("t5_pre_valid", 32'(rsp_valid_o), 32'd1);
        chk("t5_pre_busy", 32'(busy_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("t5_valid_drop", 32'(rsp_valid_o), 32'd0);
        chk("t5_busy_drop", 32'(busy_o), 32'd0);
        chk("t5_gnt_drop", 32'(gnt_o), 32'd0);
        @(posedge clk_i); #3;
        rst_i = 1'b0;
        model_reset();
        run_cycle(2'b11, 2'b00, {8'h01, 8'h00}, g, v, d, b);
        chk("t5_rr_from0", 32'(g), 32'd1);

        // Random traffic obeying the hold-until-grant handshake
        pend = '0;
        for (int k = 0; k < N; k++) rb[k] = 8'h00;
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 3400; c++) begin
                for (int k = 0; k < N; k++) begin
                    if (!pend[k] && $urandom_range(0, 99) < 70) begin
                        pend[k] = 1'b1;
                        rb[k] = 8'($urandom_range(0, 255));
                    end
                    lk[k] = ($urandom_range(0, 99) < pct[ph]);
                end
                run_cycle(pend, lk, {rb[1], rb[0]}, g, v, d, b);
                pend = pend & ~g;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
